// File: rtl/fir_inverse.sv
// fir_inverse: inverse (deconvolution) filter for the 4-tap FIR h = {1, H1, H2, H3}.
// Recovers x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3] (mod 2^WIDTH) using one
// shared multiplier sequenced over three MAC states.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   clear               - history flush, honoured only in IDLE
//   in_valid/in_ready   - input handshake, datain carries y[n]
//   out_valid/out_ready - output handshake, dataout carries x[n]
//   busy                - FSM is not in IDLE
module fir_inverse #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] H1   = WIDTH'(3),
    parameter logic [WIDTH-1:0] H2   = WIDTH'(2),
    parameter logic [WIDTH-1:0] H3   = WIDTH'(-1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC1 = 3'd1,
        MAC2 = 3'd2,
        MAC3 = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] x3_q, x3_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] coef;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc_sub;

    // Shared multiplier: tap/history pair selected by the current MAC state.
    // Low WIDTH bits of the product are identical for signed and unsigned operands.
    always_comb begin
        coef = H3;
        opnd = x3_q;
        case (state_q)
            MAC1:    begin coef = H1; opnd = x1_q; end
            MAC2:    begin coef = H2; opnd = x2_q; end
            default: begin coef = H3; opnd = x3_q; end
        endcase
        prod    = coef * opnd;
        acc_sub = acc_q - prod;
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        x3_d      = x3_q;
        dataout_d = dataout_q;

        case (state_q)
            IDLE: begin
                // clear wins on history but a coincident sample is still accepted
                if (clear) begin
                    x1_d = '0;
                    x2_d = '0;
                    x3_d = '0;
                end
                if (in_valid) begin
                    acc_d   = datain;
                    state_d = MAC1;
                end
            end
            MAC1: begin
                acc_d   = acc_sub;
                state_d = MAC2;
            end
            MAC2: begin
                acc_d   = acc_sub;
                state_d = MAC3;
            end
            MAC3: begin
                acc_d     = acc_sub;
                dataout_d = acc_sub;
                state_d   = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    x3_d    = x2_q;
                    x2_d    = x1_q;
                    x1_d    = acc_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            dataout_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            dataout_q   <= dataout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    assign busy      = busy_q;

endmodule
